// File: rtl/pcm2pdm_pkg.sv
// ---------------------------------------------------------------------------
// pcm2pdm_pkg
// Shared constants, types and small helpers for the PCM-to-PDM playback path.
//   MOD_WIDTH           default signed width of the modulator integrators
//   FB_POS / FB_NEG     feedback values for a PDM '1' / '0'
//   LFSR_SEED/LFSR_TAPS dither LFSR seed and tap mask (taps 16,14,13,11)
//   player_fsm_t        playback FSM states
//   modulator_state_t   snapshot of the modulator integrators and output bit
// ---------------------------------------------------------------------------
package pcm2pdm_pkg;

    localparam int MOD_WIDTH = 24;

    localparam int FB_POS = 32767;
    localparam int FB_NEG = -32768;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Tap 16 is bit 15, tap 14 is bit 13, tap 13 is bit 12, tap 11 is bit 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE,
        RUN
    } player_fsm_t;

    typedef struct packed {
        logic signed [MOD_WIDTH-1:0] int1;
        logic signed [MOD_WIDTH-1:0] int2;
        logic                        pdmBit;
    } modulator_state_t;

    // An oversampling ratio below 2 would leave the bit counter without a
    // distinct boundary, so it is promoted to 2.
    function automatic logic [6:0] osrEffective(input logic [6:0] osr);
        return (osr < 7'd2) ? 7'd2 : osr;
    endfunction

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/player_audio_pipeline_if.sv
// ---------------------------------------------------------------------------
// player_audio_pipeline_if
// PCM sample stream into the playback path (valid/ready handshake).
//   pcm    signed Q1.15 sample
//   valid  pcm holds a sample
//   ready  sample buffer can accept
// Modports: master (sample source, e.g. APU FIFO), slave (player).
// ---------------------------------------------------------------------------
interface player_audio_pipeline_if;

    logic signed [15:0] pcm;
    logic               valid;
    logic               ready;

    modport master (
        output pcm,
        output valid,
        input  ready
    );

    modport slave (
        input  pcm,
        input  valid,
        output ready
    );

endinterface

// File: rtl/delta_sigma_modulator.sv
// ---------------------------------------------------------------------------
// delta_sigma_modulator
// Second-order 1-bit delta-sigma modulator with saturating integrators.
// Advances one step per strobe_i.
//   clk_i     system clock
//   rst_n_i   synchronous active-low reset
//   clear_i   synchronous clear of the integrators and output bit
//   strobe_i  advance one modulator step
//   x_i       signed 16-bit modulator input
//   pdm_o     registered 1-bit output
// ---------------------------------------------------------------------------
module delta_sigma_modulator #(
    parameter int MOD_WIDTH = 24
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clear_i,
    input  logic               strobe_i,
    input  logic signed [15:0] x_i,
    output logic               pdm_o
);
    import pcm2pdm_pkg::*;

    // Two guard bits keep integrator + input - feedback exact before clamping.
    localparam int SW = MOD_WIDTH + 2;

    localparam logic signed [MOD_WIDTH-1:0] INT_MAX = {1'b0, {(MOD_WIDTH-1){1'b1}}};
    localparam logic signed [MOD_WIDTH-1:0] INT_MIN = {1'b1, {(MOD_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]        SUM_MAX = {2'b00, INT_MAX};
    localparam logic signed [SW-1:0]        SUM_MIN = {2'b11, INT_MIN};
    localparam logic signed [SW-1:0]        FB_POS_W = SW'(FB_POS);
    localparam logic signed [SW-1:0]        FB_NEG_W = SW'(FB_NEG);

    logic signed [MOD_WIDTH-1:0] r_int1;
    logic signed [MOD_WIDTH-1:0] r_int2;
    logic                        r_pdm;

    logic signed [SW-1:0]        w_fb;
    logic signed [SW-1:0]        w_sum1;
    logic signed [SW-1:0]        w_sum2;
    logic signed [MOD_WIDTH-1:0] w_int1Next;
    logic signed [MOD_WIDTH-1:0] w_int2Next;

    // Clamp to the integrator range so a full-scale input can never wrap.
    function automatic logic signed [MOD_WIDTH-1:0] satMod(input logic signed [SW-1:0] v);
        if (v > SUM_MAX) begin
            return INT_MAX;
        end else if (v < SUM_MIN) begin
            return INT_MIN;
        end else begin
            return v[MOD_WIDTH-1:0];
        end
    endfunction

    // Next integrator values; the second stage integrates the updated first
    // stage, and both subtract the feedback of the bit currently on the line.
    always_comb begin
        w_fb       = r_pdm ? FB_POS_W : FB_NEG_W;
        w_sum1     = SW'(r_int1) + SW'(x_i) - w_fb;
        w_int1Next = satMod(w_sum1);
        w_sum2     = SW'(r_int2) + SW'(w_int1Next) - w_fb;
        w_int2Next = satMod(w_sum2);
    end

    // Modulator state advances only on a strobe; clear wipes it back to zero.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            r_int1 <= '0;
            r_int2 <= '0;
            r_pdm  <= 1'b0;
        end else if (strobe_i) begin
            r_int1 <= w_int1Next;
            r_int2 <= w_int2Next;
            r_pdm  <= ~w_int2Next[MOD_WIDTH-1];
        end
    end

    assign pdm_o = r_pdm;

endmodule

// File: rtl/player_audio_pipeline.sv
// ---------------------------------------------------------------------------
// player_audio_pipeline
// PCM-to-PDM playback path: 1-entry sample buffer, zero-order hold of each
// sample for osr_i PDM bits, second-order delta-sigma modulator, and the PDM
// bit clock for the amplifier. Stereo uses two instances.
//   clk_i            system clock (single domain)
//   rst_n_i          synchronous active-low reset
//   clk_en_i         block enable; low flushes and halts everything
//   pcm_if           slave sample stream (pcm / valid / ready)
//   osr_i            PDM bits per PCM sample (values below 2 act as 2)
//   clock_divider_i  pdm_clk_o half period minus 1, in clk_i cycles
//   pdm_clk_o        PDM bit clock
//   pdm_o            PDM bitstream, changes on the falling edge of pdm_clk_o
//   underrun_o       one-cycle pulse: sample boundary in RUN with empty buffer
// Build option: define PLAYER_DITHER_EN to add +-4 LSB LFSR dither to the
// modulator input; without it the held sample is used exactly.
// ---------------------------------------------------------------------------
module player_audio_pipeline #(
    parameter int MOD_WIDTH     = 24,
    parameter int DIVIDER_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clk_en_i,
    player_audio_pipeline_if.slave   pcm_if,
    input  logic [6:0]               osr_i,
    input  logic [DIVIDER_WIDTH-1:0] clock_divider_i,
    output logic                     pdm_clk_o,
    output logic                     pdm_o,
    output logic                     underrun_o
);
    import pcm2pdm_pkg::*;

    logic [DIVIDER_WIDTH-1:0] r_divCnt;
    logic                     r_pdmClk;
    logic [6:0]               r_bitCnt;
    logic                     r_bufFull;
    logic signed [15:0]       r_bufData;
    logic signed [15:0]       r_curSample;
    player_fsm_t              r_state;
    logic                     r_underrun;

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_strobe;
    logic                     w_boundary;
    logic [6:0]               w_osrEff;
    logic signed [15:0]       w_runSample;
    logic signed [15:0]       w_x;

    // The buffer only takes a sample while enabled and out of reset.
    assign w_ready      = clk_en_i & rst_n_i & ~r_bufFull;
    assign w_accept     = pcm_if.valid & w_ready;
    assign pcm_if.ready = w_ready;

    // A bit strobe is the cycle in which the bit clock falls; the amplifier
    // samples on the rising edge, so pdm_o is stable half a period before it.
    assign w_strobe   = clk_en_i & r_pdmClk & (r_divCnt == clock_divider_i);
    assign w_osrEff   = osrEffective(osr_i);
    assign w_boundary = w_strobe & (r_bitCnt == (w_osrEff - 7'd1));

    // Bit clock divider: count 0..clock_divider_i, then toggle and wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !clk_en_i) begin
            r_divCnt <= '0;
            r_pdmClk <= 1'b0;
        end else if (r_divCnt == clock_divider_i) begin
            r_divCnt <= '0;
            r_pdmClk <= ~r_pdmClk;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    // Bit counter: counts strobes within one held sample.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !clk_en_i) begin
            r_bitCnt <= '0;
        end else if (w_strobe) begin
            r_bitCnt <= w_boundary ? 7'd0 : r_bitCnt + 7'd1;
        end
    end

    // Buffer and playback FSM. At each boundary a full buffer moves into the
    // held sample (leaving IDLE on the first one); an empty buffer in RUN keeps
    // the old sample and flags an underrun. A load and an acceptance never
    // coincide because acceptance requires an empty buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !clk_en_i) begin
            r_state     <= IDLE;
            r_bufFull   <= 1'b0;
            r_bufData   <= '0;
            r_curSample <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_boundary) begin
                if (r_bufFull) begin
                    r_curSample <= r_bufData;
                    r_bufFull   <= 1'b0;
                    r_state     <= RUN;
                end else if (r_state == RUN) begin
                    r_underrun <= 1'b1;
                end
            end
            if (w_accept) begin
                r_bufFull <= 1'b1;
                r_bufData <= pcm_if.pcm;
            end
        end
    end

`ifdef PLAYER_DITHER_EN
    logic [15:0]        r_lfsr;
    logic signed [16:0] w_dithered;

    // Dither LFSR steps once per PDM bit and restarts from the seed whenever
    // the block is flushed, so playback is repeatable after each enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !clk_en_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_strobe) begin
            r_lfsr <= lfsrNext(r_lfsr);
        end
    end

    // Offset of lfsr[2:0]-4 spans -4..+3; the result is clamped to 16 bits.
    assign w_dithered  = 17'(r_curSample) + $signed({14'b0, r_lfsr[2:0]}) - 17'sd4;
    assign w_runSample = (w_dithered[16] != w_dithered[15])
                       ? (w_dithered[16] ? 16'sh8000 : 16'sh7FFF)
                       : w_dithered[15:0];
`else
    assign w_runSample = r_curSample;
`endif

    // IDLE idles the line at 50% density by feeding zero.
    assign w_x = (r_state == RUN) ? w_runSample : 16'sd0;

    delta_sigma_modulator #(
        .MOD_WIDTH (MOD_WIDTH)
    ) u_modulator (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (~clk_en_i),
        .strobe_i (w_strobe),
        .x_i      (w_x),
        .pdm_o    (pdm_o)
    );

    assign pdm_clk_o  = r_pdmClk;
    assign underrun_o = r_underrun;

endmodule

// File: tb/tb_player_audio_pipeline.sv
// ---------------------------------------------------------------------------
// tb_player_audio_pipeline
// Directed self-checking bench for player_audio_pipeline: reset state, idle
// and constant-sample densities, handshake rate, underrun pulses,
// integrator saturation, and enable flush / restart timing.
// ---------------------------------------------------------------------------
module tb_player_audio_pipeline;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       clk_en_i;
    logic [6:0] osr_i;
    logic [7:0] clock_divider_i;
    logic       pdm_clk_o;
    logic       pdm_o;
    logic       underrun_o;

    int passCount  = 0;
    int checkCount = 0;

    player_audio_pipeline_if pcmBus();

    player_audio_pipeline #(
        .MOD_WIDTH     (24),
        .DIVIDER_WIDTH (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .clk_en_i        (clk_en_i),
        .pcm_if          (pcmBus),
        .osr_i           (osr_i),
        .clock_divider_i (clock_divider_i),
        .pdm_clk_o       (pdm_clk_o),
        .pdm_o           (pdm_o),
        .underrun_o      (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Runs exactly n cycles, counting bit-clock rising edges, ones seen on
    // those edges, and underrun pulses.
    task automatic runCycles(input int n, output int bits, output int ones, output int unders);
        logic prevClk;
        bits    = 0;
        ones    = 0;
        unders  = 0;
        prevClk = pdm_clk_o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (pdm_clk_o && !prevClk) begin
                bits++;
                if (pdm_o) ones++;
            end
            if (underrun_o) unders++;
            prevClk = pdm_clk_o;
        end
    endtask

    // Flushes the block so the ratio and divider can change safely.
    task automatic reconfigure(input logic [6:0] osr, input logic [7:0] div);
        @(negedge clk_i);
        clk_en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        osr_i           = osr;
        clock_divider_i = div;
        @(negedge clk_i);
        clk_en_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i         = 1'b0;
        clk_en_i        = 1'b1;
        osr_i           = 7'd64;
        clock_divider_i = 8'd1;
        pcmBus.pcm      = 16'sd0;
        pcmBus.valid    = 1'b1;
        repeat (4) @(negedge clk_i);
        checkCount++;
        if (pcmBus.ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", pcmBus.ready);
        else passCount++;
        checkCount++;
        if (pdm_clk_o !== 1'b0) $display("[TB] FAIL reset_pdm_clk: got %b expected 0", pdm_clk_o);
        else passCount++;
        checkCount++;
        if (pdm_o !== 1'b0) $display("[TB] FAIL reset_pdm: got %b expected 0", pdm_o);
        else passCount++;
        checkCount++;
        if (underrun_o !== 1'b0) $display("[TB] FAIL reset_underrun: got %b expected 0", underrun_o);
        else passCount++;
        rst_n_i = 1'b1;
    endtask

    task automatic test_zero_stream();
        int bits, ones, unders;
        int rise0, rise1, found;
        logic prevClk;
        pcmBus.pcm   = 16'sd0;
        pcmBus.valid = 1'b1;
        runCycles(1024, bits, ones, unders);
        checkCount++;
        if (bits != 256) $display("[TB] FAIL zero_bits: got %0d expected 256", bits);
        else passCount++;
        checkCount++;
        if (ones < 126 || ones > 130) $display("[TB] FAIL zero_density: got %0d ones expected 126..130", ones);
        else passCount++;
        checkCount++;
        if (unders != 0) $display("[TB] FAIL zero_underrun: got %0d expected 0", unders);
        else passCount++;
        rise0   = 0;
        rise1   = 0;
        found   = 0;
        prevClk = pdm_clk_o;
        for (int i = 0; i < 40 && found < 2; i++) begin
            @(negedge clk_i);
            if (pdm_clk_o && !prevClk) begin
                if (found == 0) rise0 = i;
                else rise1 = i;
                found++;
            end
            prevClk = pdm_clk_o;
        end
        checkCount++;
        if (rise1 - rise0 != 4) $display("[TB] FAIL pdm_clk_period: got %0d expected 4", rise1 - rise0);
        else passCount++;
    endtask

    task automatic test_density();
        int bits, ones, unders;
        pcmBus.pcm = 16'sh4000;
        runCycles(768, bits, ones, unders);
        runCycles(4096, bits, ones, unders);
        checkCount++;
        if (ones < 758 || ones > 778) $display("[TB] FAIL density_4000: got %0d ones of %0d expected 758..778", ones, bits);
        else passCount++;
        pcmBus.pcm = 16'shC000;
        runCycles(768, bits, ones, unders);
        runCycles(4096, bits, ones, unders);
        checkCount++;
        if (ones < 246 || ones > 266) $display("[TB] FAIL density_C000: got %0d ones of %0d expected 246..266", ones, bits);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int acc[3];
        int nAcc;
        logic readyAfter, readyMid;
        pcmBus.pcm   = 16'sd0;
        pcmBus.valid = 1'b1;
        reconfigure(7'd32, 8'd3);
        nAcc       = 0;
        readyAfter = 1'b1;
        readyMid   = 1'b1;
        for (int i = 0; i < 1500 && nAcc < 3; i++) begin
            @(negedge clk_i);
            if (nAcc >= 2 && i == acc[1] + 1) readyAfter = pcmBus.ready;
            if (nAcc >= 2 && i == acc[1] + 128) readyMid = pcmBus.ready;
            if (pcmBus.valid && pcmBus.ready) begin
                acc[nAcc] = i;
                nAcc++;
            end
        end
        checkCount++;
        if (nAcc != 3) $display("[TB] FAIL accept_count: got %0d expected 3", nAcc);
        else passCount++;
        checkCount++;
        if (nAcc == 3 && acc[1] - acc[0] != 256) $display("[TB] FAIL accept_gap1: got %0d expected 256", acc[1] - acc[0]);
        else if (nAcc == 3) passCount++;
        checkCount++;
        if (nAcc == 3 && acc[2] - acc[1] != 256) $display("[TB] FAIL accept_gap2: got %0d expected 256", acc[2] - acc[1]);
        else if (nAcc == 3) passCount++;
        checkCount++;
        if (readyAfter !== 1'b0) $display("[TB] FAIL ready_full_after: got %b expected 0", readyAfter);
        else passCount++;
        checkCount++;
        if (readyMid !== 1'b0) $display("[TB] FAIL ready_full_mid: got %b expected 0", readyMid);
        else passCount++;
    endtask

    task automatic test_underrun();
        int bits, ones, unders;
        pcmBus.pcm = 16'sh4000;
        runCycles(1024, bits, ones, unders);
        pcmBus.valid = 1'b0;
        runCycles(512, bits, ones, unders);
        runCycles(2048, bits, ones, unders);
        checkCount++;
        if (unders != 8) $display("[TB] FAIL underrun_count: got %0d expected 8", unders);
        else passCount++;
        checkCount++;
        if (ones < 189 || ones > 195) $display("[TB] FAIL underrun_density: got %0d ones of %0d expected 189..195", ones, bits);
        else passCount++;
    endtask

    task automatic test_saturation();
        int bits, ones, unders;
        pcmBus.pcm   = 16'sh7FFF;
        pcmBus.valid = 1'b1;
        reconfigure(7'd64, 8'd0);
        runCycles(512, bits, ones, unders);
        runCycles(8192, bits, ones, unders);
        checkCount++;
        if (bits != 4096 || ones < 4092) $display("[TB] FAIL sat_pos_density: got %0d ones of %0d expected >=4092 of 4096", ones, bits);
        else passCount++;
        pcmBus.pcm = 16'sh8000;
        runCycles(512, bits, ones, unders);
        runCycles(2048, bits, ones, unders);
        checkCount++;
        if (ones > 1) $display("[TB] FAIL sat_neg_density: got %0d ones of %0d expected <=1", ones, bits);
        else passCount++;
    endtask

    task automatic test_enable_flush();
        int bits, ones, unders, n;
        logic found, prevClk;
        pcmBus.pcm   = 16'sh4000;
        pcmBus.valid = 1'b1;
        reconfigure(7'd64, 8'd1);
        runCycles(600, bits, ones, unders);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk_i);
            if (pdm_clk_o && pdm_o) found = 1'b1;
        end
        checkCount++;
        if (found !== 1'b1) $display("[TB] FAIL flush_setup: got %b expected 1", found);
        else passCount++;
        clk_en_i     = 1'b0;
        pcmBus.valid = 1'b0;
        @(negedge clk_i);
        checkCount++;
        if (pdm_clk_o !== 1'b0) $display("[TB] FAIL flush_pdm_clk: got %b expected 0", pdm_clk_o);
        else passCount++;
        checkCount++;
        if (pdm_o !== 1'b0) $display("[TB] FAIL flush_pdm: got %b expected 0", pdm_o);
        else passCount++;
        checkCount++;
        if (pcmBus.ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b expected 0", pcmBus.ready);
        else passCount++;
        repeat (3) @(negedge clk_i);
        clk_en_i = 1'b1;
        #1;
        checkCount++;
        if (pcmBus.ready !== 1'b1) $display("[TB] FAIL reenable_ready: got %b expected 1", pcmBus.ready);
        else passCount++;
        n       = 0;
        prevClk = pdm_clk_o;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            n++;
            if (prevClk && !pdm_clk_o) break;
            prevClk = pdm_clk_o;
        end
        checkCount++;
        if (n != 4) $display("[TB] FAIL first_strobe_delay: got %0d expected 4", n);
        else passCount++;
        checkCount++;
        if (pdm_o !== 1'b1) $display("[TB] FAIL first_bit_cleared: got %b expected 1", pdm_o);
        else passCount++;
        runCycles(1024, bits, ones, unders);
        checkCount++;
        if (unders != 0) $display("[TB] FAIL idle_underrun: got %0d expected 0", unders);
        else passCount++;
        checkCount++;
        if (ones < 126 || ones > 130) $display("[TB] FAIL idle_density: got %0d ones of %0d expected 126..130", ones, bits);
        else passCount++;
    endtask

    initial begin
        $display("[TB] player_audio_pipeline bench start");
        test_reset();
        test_zero_stream();
        test_density();
        test_back_to_back();
        test_underrun();
        test_saturation();
        test_enable_flush();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Last-resort guard against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
